// File: rtl/parity_check_stream_pkg.sv
// parity_pkg: constants and types shared by the parity checker slice.
//   PAR_EVEN / PAR_ODD : values of odd_mode selecting the expected parity
//   state_t            : alarm state machine encoding (ST_OK, ST_ALARM)
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic {
    ST_OK    = 1'b0,
    ST_ALARM = 1'b1
  } state_t;

endpackage

// File: rtl/parity_check_stream_if.sv
// parity_check_stream_if: word stream into and out of the parity checker.
//   Input side : in_valid, in_ready, in_data, in_par, odd_mode
//   Output side: out_valid, out_ready, out_data, out_err
//   modport master : the producer/consumer around the checker
//   modport slave  : the checker itself
interface parity_check_stream_if #(
  parameter int DATA_W = 8
);

  logic              odd_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output odd_mode, in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  odd_mode, in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/parity_check_stream_calc.sv
// parity_calc: combinational parity check of one word.
//   in_data  : data word
//   in_par   : received parity bit
//   odd_mode : PAR_ODD = odd parity expected, PAR_EVEN = even parity expected
//   err      : 1 when the word plus parity bit violates the selected parity
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              odd_mode,
  output logic              err
);

  // The XOR reduction is 1 for an odd number of ones; in odd mode that is the
  // correct case, so the mode bit inverts the sense.
  assign err = (^{in_data, in_par}) ^ (odd_mode == PAR_ODD);

endmodule

// File: rtl/parity_check_stream.sv
// parity_check_stream: streaming parity checker with one registered output
// stage, a saturating error counter and a consecutive-error alarm.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of err_cnt, consecutive count and alarm
//   s          : stream interface (slave side), see parity_check_stream_if
//   err_cnt    : total parity errors, saturates at all-ones
//   alarm      : high once ERR_LIMIT consecutive errors are seen, until clr
module parity_check_stream
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  parity_check_stream_if.slave s,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               alarm
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ERR_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic              err_p0;
  logic              acc_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              err_p1;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0]  run_inc;
  state_t            state_q;
  state_t            state_nxt;

  // ---- stage 0: combinational check and handshake ----
  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .in_data  (s.in_data),
    .in_par   (s.in_par),
    .odd_mode (s.odd_mode),
    .err      (err_p0)
  );

  assign s.in_ready = ~vld_p1 | s.out_ready;
  assign acc_p0     = s.in_valid & s.in_ready;
  assign run_inc    = sat_inc(run_cnt_q);

  // ---- stage 1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (acc_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= s.in_data;
      err_p1  <= err_p0;
    end else if (s.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign s.out_valid = vld_p1;
  assign s.out_data  = data_p1;
  assign s.out_err   = err_p1;

  // Counters update on the accepting edge; clr outranks a coincident error
  // so the word that arrives with clr is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      run_cnt_q <= '0;
    end else if (clr) begin
      err_cnt_q <= '0;
      run_cnt_q <= '0;
    end else if (acc_p0) begin
      if (err_p0) begin
        err_cnt_q <= sat_inc(err_cnt_q);
        run_cnt_q <= run_inc;
      end else begin
        run_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OK;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Good words never leave ALARM; only clr does.
  always_comb begin
    state_nxt = state_q;
    if (clr) begin
      state_nxt = ST_OK;
    end else if (state_q == ST_OK && acc_p0 && err_p0 && run_inc == LIMIT) begin
      state_nxt = ST_ALARM;
    end
  end

  assign err_cnt = err_cnt_q;
  assign alarm   = (state_q == ST_ALARM);

endmodule

// File: tb/tb_parity_check_stream.sv
module tb_parity_check_stream;
  import parity_pkg::*;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 2;
  localparam int ERR_LIMIT = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic [CNT_W-1:0] err_cnt;
  logic             alarm;

  parity_check_stream_if #(.DATA_W(DATA_W)) bus ();

  parity_check_stream #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .ERR_LIMIT (ERR_LIMIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .s       (bus),
    .err_cnt (err_cnt),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: what the block should show after the most recent edge.
  int m_cnt   = 0;
  int m_run   = 0;
  bit m_alarm = 0;
  bit m_ov    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Parity rule stated in terms of the count of ones, parity bit included.
  function automatic bit ref_err(input logic [DATA_W-1:0] d, input bit p, input bit odd);
    int  ones;
    bit  good;
    ones = $countones(d) + int'(p);
    good = odd ? (ones % 2 == 1) : (ones % 2 == 0);
    return !good;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_run   = 0;
    m_alarm = 0;
    m_ov    = 0;
    sbq.delete();
  endtask

  // One clock of stimulus: check visible state, drive, predict next edge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit p,
                       input bit o, input bit c, input bit r);
    bit acc;
    bit e;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_par    = p;
    bus.odd_mode  = o;
    bus.out_ready = r;
    clr           = c;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!m_ov || r));
    acc = v && (!m_ov || r);
    e   = ref_err(d, p, o);
    if (acc) sbq.push_back('{d, e});
    if (acc)    m_ov = 1;
    else if (r) m_ov = 0;
    if (c) begin
      m_cnt   = 0;
      m_run   = 0;
      m_alarm = 0;
    end else if (acc) begin
      if (e) begin
        m_cnt = min_int(m_cnt + 1, CNT_MAX);
        m_run = min_int(m_run + 1, CNT_MAX);
        if (m_run == ERR_LIMIT) m_alarm = 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Monitor: every word consumed downstream must match the scoreboard head.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got data %0h, expected no word", bus.out_data);
        end else begin
          x = sbq.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(x.d));
          chk("out_err", 32'(bus.out_err), 32'(x.e));
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = 1'b0;
    bus.odd_mode  = PAR_ODD;
    bus.out_ready = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", 32'(bus.out_data), 32'd0);
    chk("rst out_err", 32'(bus.out_err), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst alarm", 32'(alarm), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode check: A5 has four ones
    cycle(1, 8'hA5, 1, PAR_ODD,  0, 1);
    cycle(1, 8'hA5, 0, PAR_ODD,  0, 1);
    cycle(1, 8'hA5, 1, PAR_EVEN, 0, 1);
    cycle(1, 8'hA5, 0, PAR_EVEN, 0, 1);
    cycle(0, 8'h00, 0, PAR_ODD,  0, 1);

    // Backpressure: first word must stay on the output while stalled
    cycle(1, 8'h11, 1, PAR_ODD, 0, 0);
    cycle(1, 8'h22, 1, PAR_ODD, 0, 0);
    cycle(1, 8'h22, 1, PAR_ODD, 0, 0);
    chk("hold out_data", 32'(bus.out_data), 32'h11);
    cycle(1, 8'h22, 1, PAR_ODD, 0, 1);
    cycle(1, 8'h33, 0, PAR_ODD, 0, 1);
    cycle(1, 8'h44, 0, PAR_ODD, 0, 1);
    cycle(0, 8'h00, 0, PAR_ODD, 0, 1);

    // Alarm: err, err, good, err, err, err
    cycle(0, 8'h00, 0, PAR_ODD, 1, 1);
    cycle(1, 8'hA5, 0, PAR_ODD, 0, 1);
    cycle(1, 8'hA5, 0, PAR_ODD, 0, 1);
    cycle(1, 8'hA5, 1, PAR_ODD, 0, 1);
    cycle(1, 8'hA5, 0, PAR_ODD, 0, 1);
    cycle(1, 8'hA5, 0, PAR_ODD, 0, 1);
    chk("alarm before limit", 32'(alarm), 32'd0);
    cycle(1, 8'hA5, 0, PAR_ODD, 0, 1);
    cycle(1, 8'h01, 0, PAR_ODD, 0, 1);
    chk("alarm at limit", 32'(alarm), 32'd1);
    cycle(1, 8'h03, 1, PAR_ODD, 0, 1);
    cycle(0, 8'h00, 0, PAR_ODD, 0, 1);
    chk("alarm sticky", 32'(alarm), 32'd1);

    // Clear coincident with an erroneous word
    cycle(1, 8'h5A, 0, PAR_ODD, 1, 1);
    cycle(0, 8'h00, 0, PAR_ODD, 0, 1);
    chk("clr err_cnt", 32'(err_cnt), 32'd0);
    chk("clr alarm", 32'(alarm), 32'd0);

    // Saturation at all-ones
    for (int i = 0; i < 5; i++) cycle(1, 8'(i), ref_err(8'(i), 0, PAR_ODD) ? 1'b0 : 1'b1,
                                       PAR_ODD, 0, 1);
    cycle(0, 8'h00, 0, PAR_ODD, 0, 1);
    chk("sat err_cnt", 32'(err_cnt), 32'(CNT_MAX));

    // Randomised traffic
    begin
      bit o;
      o = PAR_ODD;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(15) == 0) o = ~o;
        cycle($urandom_range(3) != 0, 8'($urandom), 1'($urandom), o,
              $urandom_range(31) == 0, $urandom_range(2) != 0);
      end
    end

    // Reset while a word is stalled on the output
    cycle(0, 8'h00, 0, PAR_ODD, 0, 1);
    cycle(1, 8'h5A, 1, PAR_ODD, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst err_cnt", 32'(err_cnt), 32'd0);
    chk("async rst alarm", 32'(alarm), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, PAR_ODD, 0, 1);

    // Drain and confirm nothing was lost
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, PAR_ODD, 0, 1);
    #3;
    chk("scoreboard empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
